id_ex_pipeline_reg: RTL and testbench

//  ID/EX pipeline register. Sits directly downstream of the register file and decoder.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/wb_bypass_mux.sv | 44 ++++
 rtl/id_ex_pipeline_reg.sv | 153 +++++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Definitions shared by the decode/execute pipeline blocks: datapath widths,
//   the layout of the 9-bit control word produced by the decoder, and the
//   2-bit ALU operation encodings carried inside that word.
//
//   Control word layout (MSB first):
//     [8] reg_write  [7] mem_read  [6] mem_write  [5] mem_to_reg
//     [4] branch     [3] alu_src   [2:1] alu_op   [0] reserved
// ----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN    = 64;
   localparam int REG_AW  = 5;
   localparam int CTRL_W  = 9;
   localparam int FUNCT_W = 4;

   // Bit positions inside the control word
   localparam int CTRL_REG_WRITE  = 8;
   localparam int CTRL_MEM_READ   = 7;
   localparam int CTRL_MEM_WRITE  = 6;
   localparam int CTRL_MEM_TO_REG = 5;
   localparam int CTRL_BRANCH     = 4;
   localparam int CTRL_ALU_SRC    = 3;
   localparam int CTRL_ALU_OP     = 1;   // LSB of the 2-bit alu_op field
   localparam int CTRL_ALU_OP_W   = 2;
   localparam int CTRL_RSVD       = 0;   // carried through untouched

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,   // loads/stores: address add
      ALU_OP_SUB   = 2'b01,   // branch compare
      ALU_OP_RTYPE = 2'b10    // decode further from funct bits
   } alu_op_e;

   // Extract the ALU operation field from a control word
   function automatic alu_op_e ctrl_alu_op(input logic [CTRL_W-1:0] ctrl);
      return alu_op_e'(ctrl[CTRL_ALU_OP +: CTRL_ALU_OP_W]);
   endfunction

   // True when the control word describes an instruction that writes a register
   function automatic logic ctrl_writes_reg(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_REG_WRITE];
   endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// ----------------------------------------------------------------------------
// wb_bypass_mux
//   Combinational operand selector placed between the register-file read port
//   and the ID/EX register. A write-back landing on the same clock edge is not
//   yet visible on the register-file read port, so the write data is forwarded
//   here instead. Register x0 always reads as zero, which also guarantees that
//   a write-back to x0 can never be forwarded.
//
//   Ports:
//     rs            in   REG_AW  source register index
//     rdata         in   XLEN    register-file read data for rs
//     wb_reg_write  in   1       write-back stage is writing this cycle
//     wb_rd         in   REG_AW  write-back destination index
//     wb_data       in   XLEN    write-back data
//     operand       out  XLEN    selected operand
// ----------------------------------------------------------------------------
module wb_bypass_mux #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs,
   input  logic [XLEN-1:0]   rdata,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic [XLEN-1:0]   operand
);

   logic rs_is_x0;
   logic wb_hit;

   assign rs_is_x0 = (rs == '0);
   assign wb_hit   = wb_reg_write && (wb_rd == rs);

   always_comb begin
      operand = rdata;
      if (rs_is_x0) begin
         operand = '0;
      end else if (wb_hit) begin
         operand = wb_data;
      end
   end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ----------------------------------------------------------------------------
// id_ex_pipeline_reg
//   ID/EX pipeline register. Captures the decoded instruction (PC, operands,
//   immediate, register indices, control and funct bits) one cycle after
//   decode, forwarding same-cycle write-back data into the operands.
//
//   Per clock edge, in priority order:
//     flush              -> insert a bubble (everything zero, counter +1)
//     stall              -> hold every output, counter included
//     valid_in == 0      -> insert a bubble (counter +1)
//     otherwise          -> capture the decoded instruction
//
//   Ports:
//     clk, reset                 clock; asynchronous active-high reset
//     valid_in, stall, flush     slot valid and hazard-unit controls
//     pc_in, imm_in              PC and sign-extended immediate
//     rs1_in, rs2_in, rd_in      register indices
//     rdata1_in, rdata2_in       register-file read data
//     ctrl_in, funct_in          decoder control word and funct bits
//     wb_reg_write, wb_rd, wb_data   write-back port, used for forwarding
//     valid_out ... funct_out    registered copies for the EX stage
//     bubble_cnt                 saturating count of bubbles entered into EX
// ----------------------------------------------------------------------------
module id_ex_pipeline_reg #(
   parameter int XLEN   = riscv_pkg::XLEN,
   parameter int REG_AW = riscv_pkg::REG_AW,
   parameter int CNT_W  = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          valid_in,
   input  logic                          stall,
   input  logic                          flush,
   input  logic [XLEN-1:0]               pc_in,
   input  logic [REG_AW-1:0]             rs1_in,
   input  logic [REG_AW-1:0]             rs2_in,
   input  logic [REG_AW-1:0]             rd_in,
   input  logic [XLEN-1:0]               rdata1_in,
   input  logic [XLEN-1:0]               rdata2_in,
   input  logic [XLEN-1:0]               imm_in,
   input  logic [riscv_pkg::CTRL_W-1:0]  ctrl_in,
   input  logic [riscv_pkg::FUNCT_W-1:0] funct_in,
   input  logic                          wb_reg_write,
   input  logic [REG_AW-1:0]             wb_rd,
   input  logic [XLEN-1:0]               wb_data,
   output logic                          valid_out,
   output logic [XLEN-1:0]               pc_out,
   output logic [XLEN-1:0]               imm_out,
   output logic [REG_AW-1:0]             rs1_out,
   output logic [REG_AW-1:0]             rs2_out,
   output logic [REG_AW-1:0]             rd_out,
   output logic [XLEN-1:0]               op1_out,
   output logic [XLEN-1:0]               op2_out,
   output logic [riscv_pkg::CTRL_W-1:0]  ctrl_out,
   output logic [riscv_pkg::FUNCT_W-1:0] funct_out,
   output logic [CNT_W-1:0]              bubble_cnt
);

   import riscv_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Saturating increment: the counter sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_ONE;
   endfunction

   // ---- Decode side: operand forwarding ----
   logic [XLEN-1:0] op1_fwd;
   logic [XLEN-1:0] op2_fwd;

   wb_bypass_mux #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_bypass_op1 (
      .rs           (rs1_in),
      .rdata        (rdata1_in),
      .wb_reg_write (wb_reg_write),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .operand      (op1_fwd)
   );

   wb_bypass_mux #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_bypass_op2 (
      .rs           (rs2_in),
      .rdata        (rdata2_in),
      .wb_reg_write (wb_reg_write),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .operand      (op2_fwd)
   );

   // Flush overrides stall; an empty decode slot only becomes a bubble when
   // the stage is actually advancing.
   logic take_bubble;
   logic take_instr;

   assign take_bubble = flush | (~stall & ~valid_in);
   assign take_instr  = ~flush & ~stall & valid_in;

   // ---- ID/EX register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_out <= 1'b0;
         pc_out    <= '0;
         imm_out   <= '0;
         rs1_out   <= '0;
         rs2_out   <= '0;
         rd_out    <= '0;
         op1_out   <= '0;
         op2_out   <= '0;
         ctrl_out  <= '0;
         funct_out <= '0;
      end else if (take_bubble) begin
         // A bubble carries no data either, so EX never sees stale fields
         valid_out <= 1'b0;
         pc_out    <= '0;
         imm_out   <= '0;
         rs1_out   <= '0;
         rs2_out   <= '0;
         rd_out    <= '0;
         op1_out   <= '0;
         op2_out   <= '0;
         ctrl_out  <= '0;
         funct_out <= '0;
      end else if (take_instr) begin
         valid_out <= 1'b1;
         pc_out    <= pc_in;
         imm_out   <= imm_in;
         rs1_out   <= rs1_in;
         rs2_out   <= rs2_in;
         rd_out    <= rd_in;
         op1_out   <= op1_fwd;
         op2_out   <= op2_fwd;
         ctrl_out  <= ctrl_in;
         funct_out <= funct_in;
      end
   end

   // ---- Bubble counter ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_cnt <= '0;
      end else if (take_bubble) begin
         bubble_cnt <= sat_inc(bubble_cnt);
      end
   end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_pipeline_reg
//   Bench for the ID/EX register. Two instances share the same stimulus: one
//   with a 32-bit bubble counter and one with a 2-bit counter so saturation is
//   reachable. Directed table vectors, hand-written multi-cycle sequences and
//   randomized cycles are all checked against a reference model of the stage.
// ----------------------------------------------------------------------------
module tb_id_ex_pipeline_reg;

   typedef struct packed {
      logic        valid;
      logic        stall;
      logic        flush;
      logic [63:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] rd1;
      logic [63:0] rd2;
      logic [63:0] imm;
      logic [8:0]  ctrl;
      logic [3:0]  funct;
      logic        wbw;
      logic [4:0]  wbrd;
      logic [63:0] wbd;
   } in_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [63:0] imm;
      logic [63:0] op1;
      logic [63:0] op2;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [8:0]  ctrl;
      logic [3:0]  funct;
   } out_t;

   typedef struct packed {
      in_t         in;
      logic        e_valid;
      logic [63:0] e_op1;
      logic [63:0] e_op2;
      logic [8:0]  e_ctrl;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        valid_in, stall, flush, wb_reg_write;
   logic [63:0] pc_in, rdata1_in, rdata2_in, imm_in, wb_data;
   logic [4:0]  rs1_in, rs2_in, rd_in, wb_rd;
   logic [8:0]  ctrl_in;
   logic [3:0]  funct_in;

   logic        a_valid, b_valid;
   logic [63:0] a_pc, a_imm, a_op1, a_op2, b_pc, b_imm, b_op1, b_op2;
   logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
   logic [8:0]  a_ctrl, b_ctrl;
   logic [3:0]  a_funct, b_funct;
   logic [31:0] a_cnt;
   logic [1:0]  b_cnt;

   id_ex_pipeline_reg #(.XLEN(64), .REG_AW(5), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
      .pc_in(pc_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
      .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
      .ctrl_in(ctrl_in), .funct_in(funct_in), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .wb_data(wb_data), .valid_out(a_valid), .pc_out(a_pc),
      .imm_out(a_imm), .rs1_out(a_rs1), .rs2_out(a_rs2), .rd_out(a_rd),
      .op1_out(a_op1), .op2_out(a_op2), .ctrl_out(a_ctrl), .funct_out(a_funct),
      .bubble_cnt(a_cnt)
   );

   id_ex_pipeline_reg #(.XLEN(64), .REG_AW(5), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
      .pc_in(pc_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
      .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
      .ctrl_in(ctrl_in), .funct_in(funct_in), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .wb_data(wb_data), .valid_out(b_valid), .pc_out(b_pc),
      .imm_out(b_imm), .rs1_out(b_rs1), .rs2_out(b_rs2), .rd_out(b_rd),
      .op1_out(b_op1), .op2_out(b_op2), .ctrl_out(b_ctrl), .funct_out(b_funct),
      .bubble_cnt(b_cnt)
   );

   out_t got_b;
   assign got_b = {b_valid, b_pc, b_imm, b_op1, b_op2, b_rs1, b_rs2, b_rd, b_ctrl, b_funct};

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: what EX should hold, and how many bubbles entered EX
   out_t    exp_o;
   longint  exp_bubbles;

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [63:0] fwd_operand(input logic [4:0] rs, input logic [63:0] rdata,
                                               input in_t v);
      if (rs == 5'd0) return 64'd0;
      if (v.wbw && (v.wbrd == rs)) return v.wbd;
      return rdata;
   endfunction

   function automatic logic [31:0] exp_cnt32();
      return (exp_bubbles >= 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : exp_bubbles[31:0];
   endfunction

   function automatic logic [1:0] exp_cnt2();
      return (exp_bubbles >= 3) ? 2'd3 : exp_bubbles[1:0];
   endfunction

   task automatic model_step(input in_t v);
      if (v.flush || (!v.stall && !v.valid)) begin
         exp_o = '0;
         exp_bubbles++;
      end else if (!v.stall) begin
         exp_o.valid = 1'b1;
         exp_o.pc    = v.pc;
         exp_o.imm   = v.imm;
         exp_o.rs1   = v.rs1;
         exp_o.rs2   = v.rs2;
         exp_o.rd    = v.rd;
         exp_o.ctrl  = v.ctrl;
         exp_o.funct = v.funct;
         exp_o.op1   = fwd_operand(v.rs1, v.rd1, v);
         exp_o.op2   = fwd_operand(v.rs2, v.rd2, v);
      end
   endtask

   task automatic model_reset();
      exp_o       = '0;
      exp_bubbles = 0;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".valid"}, a_valid, exp_o.valid);
      chk({tag, ".pc"},    a_pc,    exp_o.pc);
      chk({tag, ".imm"},   a_imm,   exp_o.imm);
      chk({tag, ".op1"},   a_op1,   exp_o.op1);
      chk({tag, ".op2"},   a_op2,   exp_o.op2);
      chk({tag, ".rs1"},   a_rs1,   exp_o.rs1);
      chk({tag, ".rs2"},   a_rs2,   exp_o.rs2);
      chk({tag, ".rd"},    a_rd,    exp_o.rd);
      chk({tag, ".ctrl"},  a_ctrl,  exp_o.ctrl);
      chk({tag, ".funct"}, a_funct, exp_o.funct);
      chk({tag, ".cnt"},   a_cnt,   exp_cnt32());
      chk({tag, ".sat_all"}, got_b, exp_o);
      chk({tag, ".sat_cnt"}, b_cnt, exp_cnt2());
   endtask

   task automatic drive(input in_t v);
      valid_in     = v.valid;
      stall        = v.stall;
      flush        = v.flush;
      pc_in        = v.pc;
      rs1_in       = v.rs1;
      rs2_in       = v.rs2;
      rd_in        = v.rd;
      rdata1_in    = v.rd1;
      rdata2_in    = v.rd2;
      imm_in       = v.imm;
      ctrl_in      = v.ctrl;
      funct_in     = v.funct;
      wb_reg_write = v.wbw;
      wb_rd        = v.wbrd;
      wb_data      = v.wbd;
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read there too
   task automatic apply(input in_t v);
      drive(v);
      @(posedge clk);
      model_step(v);
      #1;
   endtask

   function automatic in_t rand_in();
      in_t v;
      v.valid = ($urandom_range(0, 9) < 8);
      v.stall = ($urandom_range(0, 9) < 3);
      v.flush = ($urandom_range(0, 9) < 1);
      v.pc    = {$urandom, $urandom};
      v.rs1   = 5'($urandom_range(0, 7));
      v.rs2   = 5'($urandom_range(0, 7));
      v.rd    = 5'($urandom_range(0, 31));
      v.rd1   = {$urandom, $urandom};
      v.rd2   = {$urandom, $urandom};
      v.imm   = {$urandom, $urandom};
      v.ctrl  = 9'($urandom);
      v.funct = 4'($urandom);
      v.wbw   = 1'($urandom);
      v.wbrd  = 5'($urandom_range(0, 7));
      v.wbd   = {$urandom, $urandom};
      return v;
   endfunction

   function automatic in_t mk(input logic valid, input logic stl, input logic fl,
                              input logic [4:0] rs1, input logic [63:0] rd1,
                              input logic [4:0] rs2, input logic [63:0] rd2,
                              input logic wbw, input logic [4:0] wbrd,
                              input logic [63:0] wbd, input logic [8:0] ctrl);
      in_t v;
      v = rand_in();
      v.valid = valid; v.stall = stl; v.flush = fl;
      v.rs1 = rs1; v.rd1 = rd1; v.rs2 = rs2; v.rd2 = rd2;
      v.wbw = wbw; v.wbrd = wbrd; v.wbd = wbd; v.ctrl = ctrl;
      return v;
   endfunction

   // Asynchronous reset with random inputs, released after one clock edge
   task automatic do_reset(input string tag);
      in_t v;
      v = rand_in();
      drive(v);
      reset = 1'b1;
      #2;
      model_reset();
      check_outs({tag, "_async"});
      @(posedge clk);
      #1;
      check_outs({tag, "_held"});
      reset = 1'b0;
   endtask

   vec_t  tab [7];
   string tab_name [7];

   initial begin
      in_t         v;
      out_t        snap;
      longint      snap_bubbles;
      logic [1:0]  sat_seq [5];

      reset = 1'b0;
      drive(rand_in());
      model_reset();
      #1;
      do_reset("reset");

      // {inputs, expected valid/op1/op2/ctrl}
      tab_name[0] = "first_capture";
      tab[0] = '{mk(1, 0, 0, 5'd1, 64'd2, 5'd0, 64'd3, 0, 5'd0, 64'd0, 9'h102), 1'b1, 64'd2, 64'd0, 9'h102};
      tab_name[1] = "bypass_op1";
      tab[1] = '{mk(1, 0, 0, 5'd5, 64'd0, 5'd6, 64'd44, 1, 5'd5, 64'hDEAD, 9'h150), 1'b1, 64'hDEAD, 64'd44, 9'h150};
      tab_name[2] = "no_bypass_wb_off";
      tab[2] = '{mk(1, 0, 0, 5'd5, 64'd0, 5'd6, 64'd44, 0, 5'd5, 64'hDEAD, 9'h150), 1'b1, 64'd0, 64'd44, 9'h150};
      tab_name[3] = "x0_no_bypass";
      tab[3] = '{mk(1, 0, 0, 5'd3, 64'd11, 5'd0, 64'd7, 1, 5'd0, 64'd9, 9'h0A5), 1'b1, 64'd11, 64'd0, 9'h0A5};
      tab_name[4] = "bypass_both";
      tab[4] = '{mk(1, 0, 0, 5'd7, 64'd1, 5'd7, 64'd5, 1, 5'd7, 64'd123, 9'h1FF), 1'b1, 64'd123, 64'd123, 9'h1FF};
      tab_name[5] = "flush_and_stall";
      tab[5] = '{mk(1, 1, 1, 5'd2, 64'd8, 5'd3, 64'd9, 0, 5'd0, 64'd0, 9'h1FF), 1'b0, 64'd0, 64'd0, 9'h000};
      tab_name[6] = "bubble_no_valid";
      tab[6] = '{mk(0, 0, 0, 5'd2, 64'd8, 5'd3, 64'd9, 1, 5'd2, 64'd1, 9'h1FF), 1'b0, 64'd0, 64'd0, 9'h000};

      for (int i = 0; i < 7; i++) begin
         snap_bubbles = exp_bubbles;
         apply(tab[i].in);
         check_outs(tab_name[i]);
         chk({tab_name[i], "_tv_valid"}, a_valid, tab[i].e_valid);
         chk({tab_name[i], "_tv_op1"},   a_op1,   tab[i].e_op1);
         chk({tab_name[i], "_tv_op2"},   a_op2,   tab[i].e_op2);
         chk({tab_name[i], "_tv_ctrl"},  a_ctrl,  tab[i].e_ctrl);
         if (!tab[i].e_valid) chk({tab_name[i], "_tv_cnt_inc"}, a_cnt, 32'(snap_bubbles + 1));
      end

      // Stall for three cycles with changing inputs: everything frozen
      apply(mk(1, 0, 0, 5'd4, 64'h1234, 5'd9, 64'h5678, 0, 5'd0, 64'd0, 9'h0F3));
      check_outs("pre_stall");
      snap = exp_o;
      snap_bubbles = exp_bubbles;
      for (int i = 0; i < 3; i++) begin
         v = rand_in();
         v.stall = 1'b1;
         v.flush = 1'b0;
         apply(v);
         check_outs("stall");
         chk("stall_frozen_a", {a_valid, a_pc, a_imm, a_op1, a_op2, a_rs1, a_rs2, a_rd, a_ctrl, a_funct}, snap);
         chk("stall_cnt_held", a_cnt, 32'(snap_bubbles));
      end

      // 2-bit counter saturation, then reset asserted in the middle of a stall
      do_reset("reset_sat");
      sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
         v = rand_in();
         v.valid = 1'b0;
         v.stall = 1'b0;
         v.flush = 1'b0;
         apply(v);
         check_outs("sat_bubble");
         chk("sat_seq", b_cnt, sat_seq[i]);
      end
      v = rand_in();
      v.stall = 1'b1;
      v.flush = 1'b0;
      drive(v);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("midstall_rst_cnt2", b_cnt, 2'd0);
      check_outs("midstall_rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      apply(mk(1, 0, 0, 5'd1, 64'd2, 5'd2, 64'd4, 0, 5'd0, 64'd0, 9'h101));
      check_outs("post_rst_capture");
      chk("post_rst_op1", a_op1, 64'd2);
      chk("post_rst_valid", a_valid, 1'b1);

      // Randomized cycles against the model, with one reset in the middle
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset("rand_reset");
         apply(rand_in());
         check_outs("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
